// File: rtl/pipe_reg_elastic.sv
// Elastic multi-stage pipeline register: valid/ready handshake, synchronous flush, bubble collapsing.
// Optional occupancy counter and full flag when PIPE_REG_ELASTIC_OCC_EN is defined.
module pipe_reg_elastic #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef PIPE_REG_ELASTIC_OCC_EN
  ,
  output logic [$clog2(STAGES+1)-1:0] occ,
  output logic                        full
`endif
);

  logic [STAGES-1:0] vld_p;
  logic [WIDTH-1:0]  data_p [STAGES];
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] vld_src;
  logic [WIDTH-1:0]  data_src [STAGES];
  logic              tail_full;

  // A stage may load when some stage at or below it toward the output is empty, or downstream takes.
  always_comb begin
    adv       = '0;
    tail_full = 1'b1;
    for (int i = 0; i < STAGES; i++) begin
      tail_full = 1'b1;
      for (int j = i; j < STAGES; j++) tail_full = tail_full & vld_p[j];
      adv[i] = ~tail_full | out_ready;
    end
  end

  always_comb begin
    vld_src[0]  = in_valid;
    data_src[0] = in_data;
    for (int i = 1; i < STAGES; i++) begin
      vld_src[i]  = vld_p[i-1];
      data_src[i] = data_p[i-1];
    end
  end

  assign in_ready  = adv[0] & ~flush & rst_n;
  assign out_valid = vld_p[STAGES-1];
  assign out_data  = data_p[STAGES-1];

  // Stage registers: each stage either loads from its upstream neighbour or holds.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
      for (int i = 0; i < STAGES; i++) data_p[i] <= '0;
    end else if (flush) begin
      vld_p <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (adv[i]) begin
          vld_p[i]  <= vld_src[i];
          data_p[i] <= data_src[i];
        end
      end
    end
  end

`ifdef PIPE_REG_ELASTIC_OCC_EN
  localparam int OCC_W = $clog2(STAGES + 1);

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  assign full     = (occ == OCC_W'(STAGES));

  // Occupancy tracks accepted minus consumed payloads, in step with the valid bits.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= '0;
    end else if (flush) begin
      occ <= '0;
    end else begin
      occ <= occ + OCC_W'(in_xfer) - OCC_W'(out_xfer);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Bench for pipe_reg_elastic: four configurations share one stimulus stream and are checked
// every cycle against a slot-level behavioural model, plus directed literal checks.
module tb_pipe_reg_elastic;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, flush, in_valid, out_ready;
  logic [129:0] in_data;
  logic         ir2, ov2, ir3, ov3, ir4, ov4, ir1, ov1;
  logic [63:0]  od2, od3, od4;
  logic [129:0] od1;
`ifdef PIPE_REG_ELASTIC_OCC_EN
  logic [1:0] oc2, oc3;
  logic [2:0] oc4;
  logic [0:0] oc1;
  logic       fu2, fu3, fu4, fu1;
`endif

  pipe_reg_elastic #(.WIDTH(64), .STAGES(2)) d2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data[63:0]),
    .in_ready(ir2), .out_valid(ov2), .out_data(od2), .out_ready(out_ready)
`ifdef PIPE_REG_ELASTIC_OCC_EN
    , .occ(oc2), .full(fu2)
`endif
  );
  pipe_reg_elastic #(.WIDTH(64), .STAGES(3)) d3 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data[63:0]),
    .in_ready(ir3), .out_valid(ov3), .out_data(od3), .out_ready(out_ready)
`ifdef PIPE_REG_ELASTIC_OCC_EN
    , .occ(oc3), .full(fu3)
`endif
  );
  pipe_reg_elastic #(.WIDTH(64), .STAGES(4)) d4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data[63:0]),
    .in_ready(ir4), .out_valid(ov4), .out_data(od4), .out_ready(out_ready)
`ifdef PIPE_REG_ELASTIC_OCC_EN
    , .occ(oc4), .full(fu4)
`endif
  );
  pipe_reg_elastic #(.WIDTH(130), .STAGES(1)) d1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir1), .out_valid(ov1), .out_data(od1), .out_ready(out_ready)
`ifdef PIPE_REG_ELASTIC_OCC_EN
    , .occ(oc1), .full(fu1)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Model: each configuration is a row of slots (slot st-1 is the output end).
  bit           mv [4][8];
  logic [129:0] md [4][8];

  function automatic int st(input int n);
    case (n)
      0: return 2;
      1: return 3;
      2: return 4;
      default: return 1;
    endcase
  endfunction

  function automatic logic [129:0] mask(input int n);
    logic [129:0] m;
    m = '1;
    if (n != 3) m = {66'b0, {64{1'b1}}};
    return m;
  endfunction

  function automatic int cnt(input int n);
    int c = 0;
    for (int i = 0; i < st(n); i++) if (mv[n][i]) c++;
    return c;
  endfunction

  // When downstream is blocked, the run of full slots at the output end stays put and
  // everything upstream of it moves one slot forward; otherwise everything moves forward.
  always @(negedge clk) begin
    for (int n = 0; n < 4; n++) begin
      int k;
      k = st(n);
      if (!rst_n || flush) begin
        for (int i = 0; i < 8; i++) mv[n][i] = 1'b0;
      end else begin
        if (!out_ready) while (k > 0 && mv[n][k-1]) k--;
        for (int i = k - 1; i >= 1; i--) begin
          mv[n][i] = mv[n][i-1];
          md[n][i] = md[n][i-1];
        end
        if (k > 0) begin
          mv[n][0] = in_valid;
          md[n][0] = in_data & mask(n);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [129:0] act, input logic [129:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cmp_inst(input int n, input string nm, input logic ir, input logic ov,
                          input logic [129:0] od);
    int s = st(n);
    bit empty = 1'b0;
    logic e_ir, e_ov;
    for (int i = 0; i < s; i++) if (!mv[n][i]) empty = 1'b1;
    e_ir = rst_n & ~flush & (out_ready | empty);
    e_ov = rst_n & mv[n][s-1];
    check({nm, ".in_ready"}, 130'(ir), 130'(e_ir));
    check({nm, ".out_valid"}, 130'(ov), 130'(e_ov));
    if (!rst_n) check({nm, ".out_data_rst"}, od, '0);
    else if (e_ov) check({nm, ".out_data"}, od, md[n][s-1]);
  endtask

`ifdef PIPE_REG_ELASTIC_OCC_EN
  task automatic occ_chk(input int n, input string nm, input int occ, input logic fu);
    int e;
    e = rst_n ? cnt(n) : 0;
    check({nm, ".occ"}, 130'(occ), 130'(e));
    check({nm, ".full"}, 130'(fu), 130'(e == st(n)));
  endtask
`endif

  task automatic compare_all();
    cmp_inst(0, "s2", ir2, ov2, 130'(od2));
    cmp_inst(1, "s3", ir3, ov3, 130'(od3));
    cmp_inst(2, "s4", ir4, ov4, 130'(od4));
    cmp_inst(3, "s1", ir1, ov1, od1);
`ifdef PIPE_REG_ELASTIC_OCC_EN
    occ_chk(0, "s2", int'(oc2), fu2);
    occ_chk(1, "s3", int'(oc3), fu3);
    occ_chk(2, "s4", int'(oc4), fu4);
    occ_chk(3, "s1", int'(oc1), fu1);
`endif
  endtask

  // Inputs change one time unit after posedge (between negedges); outputs compared a unit later.
  task automatic drive(input logic iv, input logic [129:0] id, input logic orr,
                       input logic fl = 1'b0, input logic rs = 1'b1);
    @(posedge clk);
    #1;
    rst_n     = rs;
    in_valid  = iv;
    in_data   = id;
    out_ready = orr;
    flush     = fl;
    #1;
    compare_all();
  endtask

  task automatic step(input logic iv, input logic [129:0] id, input logic orr,
                      input logic fl = 1'b0, input logic rs = 1'b1);
    drive(iv, id, orr, fl, rs);
    @(negedge clk);
    #1;
  endtask

  task automatic drain();
    repeat (6) step(1'b0, '0, 1'b1);
  endtask

  logic [129:0] ones, pat;
  logic [159:0] r;

  initial begin
    ones      = '1;
    pat       = {65{2'b10}};
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("reset.out_valid", 130'(ov2), '0);
    check("reset.out_data", 130'(od2), '0);
    check("reset.in_ready", 130'(ir2), '0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1);

    // Reset mid-stream
    step(1'b1, 130'h1, 1'b1);
    step(1'b1, 130'h2, 1'b1);
    step(1'b1, 130'h3, 1'b1);
    check("midrst.pre_valid", 130'(ov2), 130'h1);
    check("midrst.pre_data", 130'(od2), 130'h2);
    drive(1'b1, 130'h4, 1'b1, 1'b0, 1'b0);
    check("midrst.out_valid", 130'(ov2), '0);
    check("midrst.out_data", 130'(od2), '0);
    check("midrst.in_ready", 130'(ir2), '0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 130'h5, 1'b1);
    check("midrst.no_stale", 130'(ov2), '0);
    step(1'b0, '0, 1'b1);
    check("midrst.first_valid", 130'(ov2), 130'h1);
    check("midrst.first_data", 130'(od2), 130'h5);
    drain();

    // Latency and throughput, three stages
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 130'(32'hA0 + i), 1'b1);
      check("lat3.in_ready", 130'(ir3), 130'h1);
      check("lat3.out_valid", 130'(ov3), 130'(i >= 2));
      if (i >= 2) check("lat3.out_data", 130'(od3), 130'(32'hA0 + i - 2));
    end
    drain();

    // Backpressure fill, two stages
    step(1'b1, 130'h11, 1'b0);
    step(1'b1, 130'h22, 1'b0);
    check("bp.full_ready", 130'(ir2), '0);
    check("bp.head", 130'(od2), 130'h11);
    step(1'b1, 130'h33, 1'b0);
    check("bp.hold_ready", 130'(ir2), '0);
    check("bp.hold_head", 130'(od2), 130'h11);
    step(1'b1, 130'h33, 1'b1);
    check("bp.second", 130'(od2), 130'h22);
    step(1'b0, '0, 1'b1);
    check("bp.third", 130'(od2), 130'h33);
    step(1'b0, '0, 1'b1);
    check("bp.empty", 130'(ov2), '0);
    drain();

    // Bubble collapse, four stages
    step(1'b1, 130'h1, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b1, 130'h2, 1'b0);
    step(1'b0, '0, 1'b0);
    check("bub.head_valid", 130'(ov4), 130'h1);
    check("bub.head_data", 130'(od4), 130'h1);
    step(1'b0, '0, 1'b0);
    check("bub.ready2", 130'(ir4), 130'h1);
    step(1'b1, 130'h3, 1'b0);
    check("bub.ready3", 130'(ir4), 130'h1);
    step(1'b1, 130'h4, 1'b0);
    check("bub.ready4", 130'(ir4), '0);
    step(1'b0, '0, 1'b1);
    check("bub.next", 130'(od4), 130'h2);
    drain();

    // Flush against simultaneous handshakes, two stages
    step(1'b1, 130'h5, 1'b0);
    step(1'b1, 130'h6, 1'b0);
    drive(1'b1, 130'h7, 1'b1, 1'b1);
    check("flush.in_ready", 130'(ir2), '0);
    check("flush.out_valid", 130'(ov2), 130'h1);
    check("flush.out_data", 130'(od2), 130'h5);
`ifdef PIPE_REG_ELASTIC_OCC_EN
    check("flush.occ_before", 130'(oc2), 130'h2);
`endif
    @(negedge clk);
    #1;
    check("flush.after", 130'(ov2), '0);
`ifdef PIPE_REG_ELASTIC_OCC_EN
    check("flush.occ_after", 130'(oc2), '0);
`endif
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b1);
      check("flush.never7", 130'(ov2), '0);
    end

    // Wide single stage
    step(1'b1, ones, 1'b0);
    check("w1.valid", 130'(ov1), 130'h1);
    check("w1.ones", od1, ones);
    step(1'b1, pat, 1'b0);
    check("w1.hold", od1, ones);
    check("w1.hold_ready", 130'(ir1), '0);
    step(1'b1, pat, 1'b1);
    check("w1.pat", od1, pat);
    step(1'b0, '0, 1'b0);
    check("w1.pat_hold", od1, pat);
    step(1'b0, '0, 1'b1);
    check("w1.empty", 130'(ov1), '0);

    // Randomized traffic with occasional flush and reset
    for (int c = 0; c < 3000; c++) begin
      r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      step($urandom_range(0, 3) != 0, r[129:0], $urandom_range(0, 1) != 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 149) != 0);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
